// File: rtl/sample_sweep_ctrl_if.sv
// Plot-point handshake between the sweep sequencer and the frame-buffer writer.
// master: sequencer side (drives the point), slave: writer side (drives ready).
interface sample_sweep_ctrl_if;
  logic        pt_valid;
  logic        pt_ready;
  logic [17:0] pt_x;
  logic [5:0]  pt_col;

  modport master (
    output pt_valid,
    output pt_x,
    output pt_col,
    input  pt_ready
  );

  modport slave (
    input  pt_valid,
    input  pt_x,
    input  pt_col,
    output pt_ready
  );
endinterface

// File: rtl/sample_sweep_ctrl.sv
// Bifurcation-sweep sequencer: steps sample_num through the mu table, loads X0
// into the map engine, discards TRANSIENT iterations, then forwards PLOT_POINTS
// iterates per sample to the plot writer over the pt handshake.
// Optional feature: define SWEEP_LOOP_EN to restart the sweep from sample 0
// while enable stays high (sweep_done still pulses once per pass).
module sample_sweep_ctrl #(
  parameter int unsigned NUM_SAMPLES = 11,
  parameter int unsigned TRANSIENT   = 64,
  parameter int unsigned PLOT_POINTS = 32,
  parameter int unsigned SETTLE      = 4,
  parameter logic [17:0] X0          = 18'h08000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable,
  output logic [5:0]                 sample_num,
  output logic                       x_load,
  output logic [17:0]                x_init,
  output logic                       iter_go,
  input  logic                       iter_done,
  input  logic [17:0]                x_in,
  sample_sweep_ctrl_if.master        pt,
  output logic                       busy,
  output logic                       sweep_done
);

  localparam logic [15:0] TransientW = 16'(TRANSIENT);
  localparam logic [15:0] PlotLast   = 16'(PLOT_POINTS - 1);
  localparam logic [7:0]  SettleLast = 8'(SETTLE - 1);
  localparam logic [5:0]  LastSample = 6'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StLoad,
    StGo,
    StWait,
    StEmit,
    StNext
  } state_e;

  state_e      state_q, state_d;
  logic        enable_q;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] trans_q, trans_d;
  logic [15:0] pts_q, pts_d;
  logic [5:0]  sample_q, sample_d;
  logic        x_load_q, x_load_d;
  logic        iter_go_q, iter_go_d;
  logic        pt_valid_q, pt_valid_d;
  logic [17:0] pt_x_q, pt_x_d;
  logic [5:0]  pt_col_q, pt_col_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  assign x_init      = X0;
  assign sample_num  = sample_q;
  assign x_load      = x_load_q;
  assign iter_go     = iter_go_q;
  assign pt.pt_valid = pt_valid_q;
  assign pt.pt_x     = pt_x_q;
  assign pt.pt_col   = pt_col_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;

  // Next state; pulse outputs are decided on the transition so they line up with the state.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    trans_d    = trans_q;
    pts_d      = pts_q;
    sample_d   = sample_q;
    pt_x_d     = pt_x_q;
    pt_col_d   = pt_col_q;
    pt_valid_d = pt_valid_q;
    x_load_d   = 1'b0;
    iter_go_d  = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (enable && !enable_q) begin
          state_d  = StSelect;
          sample_d = '0;
          settle_d = '0;
        end
      end
      StSelect: begin
        if (settle_q == SettleLast) begin
          state_d  = StLoad;
          x_load_d = 1'b1;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      StLoad: begin
        state_d   = StGo;
        iter_go_d = 1'b1;
        trans_d   = '0;
        pts_d     = '0;
      end
      StGo: begin
        state_d = StWait;
      end
      StWait: begin
        if (iter_done) begin
          if (trans_q < TransientW) begin
            trans_d   = trans_q + 16'd1;
            state_d   = StGo;
            iter_go_d = 1'b1;
          end else begin
            pt_x_d     = x_in;
            pt_col_d   = sample_q;
            pt_valid_d = 1'b1;
            state_d    = StEmit;
          end
        end
      end
      StEmit: begin
        if (pt_valid_q && pt.pt_ready) begin
          pt_valid_d = 1'b0;
          pts_d      = pts_q + 16'd1;
          if (pts_q < PlotLast) begin
            state_d   = StGo;
            iter_go_d = 1'b1;
          end else begin
            state_d = StNext;
          end
        end
      end
      StNext: begin
        if (sample_q == LastSample) begin
          done_d = 1'b1;
`ifdef SWEEP_LOOP_EN
          if (enable) begin
            sample_d = '0;
            settle_d = '0;
            state_d  = StSelect;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end else if (!enable) begin
          // Abort only at a sample boundary; sample_num keeps the last finished sample.
          state_d = StIdle;
        end else begin
          sample_d = sample_q + 6'd1;
          settle_d = '0;
          state_d  = StSelect;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= StIdle;
      enable_q   <= 1'b0;
      settle_q   <= '0;
      trans_q    <= '0;
      pts_q      <= '0;
      sample_q   <= '0;
      x_load_q   <= 1'b0;
      iter_go_q  <= 1'b0;
      pt_valid_q <= 1'b0;
      pt_x_q     <= '0;
      pt_col_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable;
      settle_q   <= settle_d;
      trans_q    <= trans_d;
      pts_q      <= pts_d;
      sample_q   <= sample_d;
      x_load_q   <= x_load_d;
      iter_go_q  <= iter_go_d;
      pt_valid_q <= pt_valid_d;
      pt_x_q     <= pt_x_d;
      pt_col_q   <= pt_col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_sample_sweep_ctrl.sv
// Bench for sample_sweep_ctrl: event-timing model of the sweep plus directed
// scenarios (reset, full sweep, backpressure, abort, spurious iter_done, loop).
module tb_sample_sweep_ctrl;
  localparam int NS = 3;
  localparam int TR = 2;
  localparam int PP = 2;
  localparam int ST = 1;
  localparam logic [17:0] X0V = 18'h08000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        enable;
  logic [5:0]  sample_num;
  logic        x_load, iter_go, iter_done, busy, sweep_done;
  logic [17:0] x_init, x_in;
  logic        eng_done, spur_done;

  sample_sweep_ctrl_if pt_if ();

  assign iter_done = eng_done | spur_done;

  sample_sweep_ctrl #(
    .NUM_SAMPLES (NS),
    .TRANSIENT   (TR),
    .PLOT_POINTS (PP),
    .SETTLE      (ST),
    .X0          (X0V)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .sample_num (sample_num),
    .x_load     (x_load),
    .x_init     (x_init),
    .iter_go    (iter_go),
    .iter_done  (iter_done),
    .x_in       (x_in),
    .pt         (pt_if),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miss = 0;
  int test_id = 0;
  int chk_req = 0;
  int chk_ack = 0;

  // Observation counters, owned by the compare process.
  int cur_id = -1;
  int cnt_load, cnt_go, cnt_done, wraps, bp_run, bp_max;
  int cols[$];
  logic [5:0] prev_sample = '0;
  logic       prev_busy = 1'b0;
  int exp_cols [6] = '{0, 0, 1, 1, 2, 2};

  // Model: expected cycle of each pulse plus expected level outputs.
  int e_go = -1, e_load = -1, e_done = -1, e_bound = -1;
  bit m_busy = 0, m_ptv = 0, m_out = 0, m_hist = 0;
  logic [5:0]  m_sample = '0, m_col = '0;
  logic [17:0] m_x = '0;
  int m_it = 0, m_pts = 0;
  bit b_n, p_n;
  logic [5:0] s_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic final_checks(input int id);
    case (id)
      1: begin
        chk("rst_go_count", cnt_go, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sample_num", sample_num, 0);
        chk("rst_pt_valid", pt_if.pt_valid, 0);
        chk("rst_pt_x", pt_if.pt_x, 0);
        chk("rst_pt_col", pt_if.pt_col, 0);
        chk("rst_x_load", x_load, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_x_init", x_init, 18'h08000);
      end
      2, 3: begin
        chk("sweep_loads", cnt_load, 3);
        chk("sweep_gos", cnt_go, 12);
        chk("sweep_points", cols.size(), 6);
        for (int i = 0; i < 6 && i < cols.size(); i++) chk("sweep_col_seq", cols[i], exp_cols[i]);
        chk("sweep_done_count", cnt_done, 1);
        chk("sweep_end_busy", busy, 0);
        chk("sweep_end_sample", sample_num, 2);
        if (id == 3) chk("bp_hold_ge5", bp_max >= 5, 1);
      end
      4: begin
        chk("abort_loads", cnt_load, 2);
        chk("abort_gos", cnt_go, 8);
        chk("abort_points", cols.size(), 4);
        for (int i = 0; i < 4 && i < cols.size(); i++) chk("abort_col_seq", cols[i], exp_cols[i]);
        chk("abort_done_count", cnt_done, 0);
        chk("abort_sample", sample_num, 1);
        chk("abort_busy", busy, 0);
      end
      5: begin
        chk("loop_done_count", cnt_done, 2);
        chk("loop_wraps", wraps, 2);
        chk("loop_end_busy", busy, 0);
      end
      default: ;
    endcase
  endtask

  // Compare process: outputs after each rising edge vs model, then advance model.
  initial begin
    forever begin
      @(negedge CLK);
      if (test_id != cur_id) begin
        cur_id = test_id;
        cnt_load = 0; cnt_go = 0; cnt_done = 0; wraps = 0; bp_run = 0; bp_max = 0;
        cols.delete();
      end

      chk("x_init", x_init, X0V);
      chk("iter_go", iter_go, cyc == e_go);
      chk("x_load", x_load, cyc == e_load);
      chk("sweep_done", sweep_done, cyc == e_done);
      chk("busy", busy, m_busy);
      chk("sample_num", sample_num, m_sample);
      chk("pt_valid", pt_if.pt_valid, m_ptv);
      chk("pt_x", pt_if.pt_x, m_x);
      chk("pt_col", pt_if.pt_col, m_col);

      if (x_load === 1'b1) cnt_load++;
      if (iter_go === 1'b1) cnt_go++;
      if (sweep_done === 1'b1) cnt_done++;
      if (pt_if.pt_valid === 1'b1 && pt_if.pt_ready === 1'b1) cols.push_back(int'(pt_if.pt_col));
      if (prev_busy && busy && prev_sample == 6'(NS - 1) && sample_num == 6'd0) wraps++;
      if (pt_if.pt_valid === 1'b1) bp_run++; else bp_run = 0;
      if (bp_run > bp_max) bp_max = bp_run;
      prev_sample = sample_num;
      prev_busy = busy;

      if (chk_req != chk_ack) begin
        final_checks(chk_req);
        chk_ack = chk_req;
      end

      if (RST !== 1'b1) begin
        m_busy = 0; m_sample = '0; m_ptv = 0; m_x = '0; m_col = '0; m_out = 0;
        e_go = -1; e_load = -1; e_done = -1; e_bound = -1;
      end else begin
        b_n = m_busy; s_n = m_sample; p_n = m_ptv;
        if (!m_busy && enable && !m_hist) begin
          b_n = 1; s_n = '0; e_load = cyc + 1 + ST;
        end
        if (cyc == e_load) begin
          e_go = cyc + 1; m_it = 0; m_pts = 0;
        end
        if (cyc == e_go) begin
          m_out = 1;
        end else if (m_out && iter_done) begin
          m_out = 0;
          m_it++;
          if (m_it <= TR) e_go = cyc + 1;
          else begin
            p_n = 1; m_x = x_in; m_col = m_sample;
          end
        end
        if (m_ptv && pt_if.pt_ready) begin
          p_n = 0;
          m_pts++;
          if (m_pts < PP) e_go = cyc + 1;
          else e_bound = cyc + 2;
        end
        if (cyc == e_bound - 1) begin
          if (m_sample == 6'(NS - 1)) begin
            e_done = cyc + 1;
`ifdef SWEEP_LOOP_EN
            if (enable) begin
              s_n = '0; e_load = cyc + 1 + ST;
            end else b_n = 0;
`else
            b_n = 0;
`endif
          end else if (!enable) begin
            b_n = 0;
          end else begin
            s_n = m_sample + 6'd1; e_load = cyc + 1 + ST;
          end
        end
        m_busy = b_n; m_sample = s_n; m_ptv = p_n;
      end
      m_hist = (RST === 1'b1) ? enable : 1'b0;
    end
  end

  // Map engine: answers each iter_go with iter_done three cycles later.
  initial begin
    int due;
    logic [17:0] val;
    due = -1;
    val = 18'h01000;
    eng_done = 1'b0;
    x_in = 18'h2AAAA;
    forever begin
      @(negedge CLK);
      if (iter_go === 1'b1) due = cyc + 3;
      @(posedge CLK);
      #1;
      if (cyc == due) begin
        eng_done = 1'b1; x_in = val; val = val + 18'h00731;
      end else begin
        eng_done = 1'b0; x_in = 18'h2AAAA;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_to_idle(input int maxc);
    bit seen;
    seen = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      if (busy) seen = 1;
      else if (seen) return;
    end
    $display("FAIL idle_timeout at cycle %0d: busy %b, expected 0", cyc, busy);
    $fatal(1, "sweep did not finish");
  endtask

  task automatic req_check(input int id);
    chk_req = id;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (chk_ack == id) return;
    end
    $display("FAIL check_timeout at cycle %0d: ack %0d, expected %0d", cyc, chk_ack, id);
    $fatal(1, "checker stalled");
  endtask

  task automatic wait_cond(input int which, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge CLK);
      case (which)
        0: if (x_load === 1'b1) return;
        1: if (pt_if.pt_valid === 1'b1) return;
        2: if (busy === 1'b1 && sample_num == 6'd1) return;
        default: if (cnt_done >= 2) return;
      endcase
    end
    $display("FAIL wait_timeout at cycle %0d: condition %0d not reached, expected within %0d",
             cyc, which, maxc);
    $fatal(1, "wait expired");
  endtask

  // Directed stimulus.
  initial begin
    RST = 1'b0;
    enable = 1'b1;
    spur_done = 1'b0;
    pt_if.pt_ready = 1'b1;
    test_id = 1;
    repeat (3) @(posedge CLK);
    req_check(1);
    step();
    RST = 1'b1;
    enable = 1'b0;

`ifndef SWEEP_LOOP_EN
    // Full sweep with a spurious iter_done in SELECT and an ignored enable edge.
    step(); step();
    test_id = 2;
    enable = 1'b1;
    step(); spur_done = 1'b1;
    step(); spur_done = 1'b0;
    wait_cond(0, 20);
    step(); enable = 1'b0;
    step(); enable = 1'b1;
    run_to_idle(400);
    req_check(2);

    // Backpressure on the first point.
    step();
    enable = 1'b0;
    pt_if.pt_ready = 1'b0;
    test_id = 3;
    step(); enable = 1'b1;
    wait_cond(1, 100);
    repeat (5) @(negedge CLK);
    step(); pt_if.pt_ready = 1'b1;
    run_to_idle(400);
    req_check(3);
`endif

    // Abort during sample 1.
    step(); enable = 1'b0; test_id = 4;
    step(); enable = 1'b1;
    wait_cond(2, 200);
    step(); enable = 1'b0;
    run_to_idle(400);
    req_check(4);

`ifdef SWEEP_LOOP_EN
    // Continuous sweeping: two wraps, then stop at the next sample boundary.
    step(); enable = 1'b0; test_id = 5;
    step(); enable = 1'b1;
    wait_cond(3, 600);
    step(); enable = 1'b0;
    run_to_idle(400);
    req_check(5);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

// File: doc/sample_sweep_ctrl.md
# sample_sweep_ctrl

Sequencer for the chaos-map bifurcation sweep. It steps `sample_num` through the mu table, loads the initial value into the map iteration engine, and runs a fixed number of transient iterations that it discards. It then forwards a fixed number of iterates per sample to the plot writer over a valid/ready handshake. It sits between the mu-selection block (driven by `sample_num`) and the frame-buffer writer (consumes `pt_*`).

## Interface

- `NUM_SAMPLES`, 11: samples per sweep, `sample_num` runs 0..NUM_SAMPLES-1 (1..64).
- `TRANSIENT`, 64: discarded iterations per sample (0..65535).
- `PLOT_POINTS`, 32: emitted iterations per sample (1..65535).
- `SETTLE`, 4: idle cycles after a `sample_num` change before loading (1..255).
- `X0`, 18'h08000: initial x, Q2.16 (0.5).

Ports:

- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: **synchronous, active-low reset.**
- `enable`, in, 1: sweep request, level; a sweep starts on its sampled rising edge.
- `sample_num`, out, 6: index to the mu-selection block.
- `x_load`, out, 1: one-cycle pulse; engine loads `x_init`.
- `x_init`, out, 18: constant `X0`.
- `iter_go`, out, 1: one-cycle pulse requesting one map iteration.
- `iter_done`, in, 1: one-cycle pulse; `x_in` is valid this cycle.
- `x_in`, in, 18: iteration result, Q2.16.
- `pt_valid`, out, 1: plot point available.
- `pt_ready`, in, 1: writer accepts the point.
- `pt_x`, out, 18: plot point value.
- `pt_col`, out, 6: sample index of the point.
- `busy`, out, 1: high in every state except IDLE.
- `sweep_done`, out, 1: one-cycle pulse after the last sample completes.

## Operation

- States and transitions:
  - IDLE
  - SELECT: settle counter runs SETTLE cycles.
  - LOAD: `x_load`=1 for one cycle.
  - GO: `iter_go`=1 for one cycle.
  - WAIT: waits for `iter_done`.
  - EMIT: holds `pt_valid` until accepted.
  - NEXT: sample bookkeeping.
- IDLE→SELECT on `enable` high with the previous-cycle `enable` register low. `sample_num`←0.
- SELECT→LOAD when the settle count reaches SETTLE-1. The count clears on entry.
- LOAD→GO. The transient counter and point counter clear.
- GO→WAIT unconditionally.
- WAIT, on `iter_done`:
  - If transient count < TRANSIENT: increment it, →GO.
  - Otherwise: capture `x_in` into `pt_x`, `pt_col`←`sample_num`, →EMIT.
- `iter_done` outside WAIT is ignored.
- EMIT, on `pt_valid && pt_ready`:
  - Point count +1.
  - If count+1 < PLOT_POINTS: →GO.
  - Otherwise: →NEXT.
- NEXT:
  - If `sample_num` = NUM_SAMPLES-1: →IDLE with `sweep_done`=1.
  - Else if `enable` low: →IDLE, no `sweep_done` (abort at sample boundary).
  - Else: `sample_num`+1, →SELECT.
- Counters are 16 bits and never wrap within a sample; the comparisons above bound them.
- `pt_x`/`pt_col` stay stable while `pt_valid` is high and not accepted.
- `pt_valid` never drops without a handshake.
- `x_in` is passed unmodified; no arithmetic is performed on it.

## Timing

- Reset values:
  - state IDLE
  - `sample_num`=0, `x_load`=0, `iter_go`=0, `pt_valid`=0, `pt_x`=0, `pt_col`=0, `busy`=0, `sweep_done`=0
  - enable history register=0
  - all counters 0
- `x_init` is constant `X0`, including during reset.
- All outputs are registered.
- Enable edge to `busy`/`sample_num` update: 1 cycle.
- SELECT entry to `x_load`: SETTLE cycles.
- `x_load` to the first `iter_go`: 1 cycle.
- `iter_done` to the next `iter_go` (transient): 1 cycle.
- `iter_done` to `pt_valid`: 1 cycle.
- Handshake to next `iter_go`: 1 cycle.
- `RST` low mid-sweep: all outputs return to reset values at that edge. No pulse or handshake completes in that cycle.
- An `enable` edge arriving while busy is ignored. The history register still tracks `enable`.

## Configuration

- `SWEEP_LOOP_EN` defined: in NEXT with `sample_num`=NUM_SAMPLES-1 and `enable` high, pulse `sweep_done`, set `sample_num`←0 and →SELECT. Sweeping runs continuously until `enable` is low at a sample boundary.
- `SWEEP_LOOP_EN` undefined: behaviour exactly as in Operation. One sweep runs per `enable` rising edge.

## Test plan

Bench parameters unless stated otherwise: NUM_SAMPLES=3, TRANSIENT=2, PLOT_POINTS=2, SETTLE=1; engine model returns `iter_done` 3 cycles after `iter_go`.

- **Reset:** hold `RST`=0 for 3 cycles with `enable`=1 → all outputs at reset values; no `iter_go`.
- **Full sweep, `pt_ready`=1:** enable rise →
  - 3 `x_load` pulses
  - 12 `iter_go` pulses total (4 per sample)
  - 6 points with `pt_col` sequence 0,0,1,1,2,2
  - exactly 1 `sweep_done`, then `busy`=0.
- **Backpressure:** `pt_ready`=0 for 5 cycles on the first point → `pt_valid` held 5+ cycles, `pt_x` unchanged, no `iter_go` until acceptance.
- **Abort:** drop `enable` during sample 1 → sample 1 completes (2 points), no `sweep_done`, IDLE with `sample_num`=1.
- **Spurious input:** `iter_done` pulse during SELECT → ignored; iteration counts still match 4 per sample.
- **Loop mode:** `SWEEP_LOOP_EN` defined, `enable` held high → `sample_num` wraps 2→0, `sweep_done` pulses once per wrap, `busy` stays 1.
